// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, write-back L1 cache controller: one word per line, hits served locally,
// misses turned into single-word writeback/fill transactions on a shared memory port.
module l1_cache_ctrl #(
  parameter int unsigned DATA_SIZE = 2,
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned ADDR_W    = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_SIZE*8-1:0]   cpu_wdata,
  output logic [DATA_SIZE*8-1:0]   cpu_rdata,
  output logic                     cpu_ready,
  output logic                     processor_req,
  output logic                     mem_read_req,
  output logic                     mem_write_req,
  output logic [ADDR_W-1:0]        addr,
  output logic [DATA_SIZE*8-1:0]   mem_write_data,
  input  logic [DATA_SIZE*8-1:0]   mem_read_data,
  input  logic                     processor_resp,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);

  localparam int unsigned DW    = DATA_SIZE * 8;
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_e;

  state_e                            state_q, state_d;
  logic [NUM_LINES-1:0]              valid_q, valid_d;
  logic [NUM_LINES-1:0]              dirty_q, dirty_d;
  logic [NUM_LINES-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_LINES-1:0][DW-1:0]      data_q, data_d;

  logic [ADDR_W-1:0]                 lat_addr_q, lat_addr_d;
  logic                              lat_we_q, lat_we_d;
  logic [DW-1:0]                     lat_wdata_q, lat_wdata_d;

  logic [DW-1:0]                     rdata_q, rdata_d;
  logic                              ready_q, ready_d;
  logic                              preq_q, preq_d;
  logic                              rdreq_q, rdreq_d;
  logic                              wrreq_q, wrreq_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [DW-1:0]                     wdata_q, wdata_d;
  logic                              seen_low_q, seen_low_d;
  logic [15:0]                       hit_cnt_q, hit_cnt_d;
  logic [15:0]                       miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]                  cpu_idx, lat_idx;
  logic [TAG_W-1:0]                  cpu_tag, lat_tag;
  logic                              lookup_hit;
  logic                              xfer_done;

  assign cpu_idx    = cpu_addr[IDX_W-1:0];
  assign cpu_tag    = cpu_addr[ADDR_W-1:IDX_W];
  assign lat_idx    = lat_addr_q[IDX_W-1:0];
  assign lat_tag    = lat_addr_q[ADDR_W-1:IDX_W];
  assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // A response only counts once it has been seen low during this request (stale-grant filter).
  assign xfer_done  = preq_q && seen_low_q && processor_resp;

  // Next-state, array update and registered-output logic
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    lat_addr_d  = lat_addr_q;
    lat_we_d    = lat_we_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    preq_d      = preq_q;
    rdreq_d     = rdreq_q;
    wrreq_d     = wrreq_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    seen_low_d  = seen_low_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    if (preq_q && !processor_resp) seen_low_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          lat_addr_d  = cpu_addr;
          lat_we_d    = cpu_we;
          lat_wdata_d = cpu_wdata;
          if (lookup_hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            if (cpu_we) begin
              data_d[cpu_idx]  = cpu_wdata;
              dirty_d[cpu_idx] = 1'b1;
            end else begin
              rdata_d = data_q[cpu_idx];
            end
            state_d = RESP;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
              preq_d     = 1'b1;
              wrreq_d    = 1'b1;
              addr_d     = {tag_q[cpu_idx], cpu_idx};
              wdata_d    = data_q[cpu_idx];
              seen_low_d = 1'b0;
              state_d    = WB;
            end else if (cpu_we) begin
              valid_d[cpu_idx] = 1'b1;
              dirty_d[cpu_idx] = 1'b1;
              tag_d[cpu_idx]   = cpu_tag;
              data_d[cpu_idx]  = cpu_wdata;
              state_d          = RESP;
            end else begin
              preq_d     = 1'b1;
              rdreq_d    = 1'b1;
              addr_d     = cpu_addr;
              seen_low_d = 1'b0;
              state_d    = FILL;
            end
          end
        end
      end

      WB: begin
        if (xfer_done) begin
          dirty_d[lat_idx] = 1'b0;
          preq_d           = 1'b0;
          wrreq_d          = 1'b0;
          addr_d           = '0;
          wdata_d          = '0;
          seen_low_d       = 1'b0;
          if (lat_we_q) begin
            valid_d[lat_idx] = 1'b1;
            dirty_d[lat_idx] = 1'b1;
            tag_d[lat_idx]   = lat_tag;
            data_d[lat_idx]  = lat_wdata_q;
            state_d          = RESP;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        // Arriving from WB the port is idle for one cycle; the fill request launches here.
        if (!preq_q) begin
          preq_d     = 1'b1;
          rdreq_d    = 1'b1;
          addr_d     = lat_addr_q;
          seen_low_d = 1'b0;
        end else if (xfer_done) begin
          valid_d[lat_idx] = 1'b1;
          dirty_d[lat_idx] = 1'b0;
          tag_d[lat_idx]   = lat_tag;
          data_d[lat_idx]  = mem_read_data;
          rdata_d          = mem_read_data;
          preq_d           = 1'b0;
          rdreq_d          = 1'b0;
          addr_d           = '0;
          seen_low_d       = 1'b0;
          state_d          = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      preq_q      <= 1'b0;
      rdreq_q     <= 1'b0;
      wrreq_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      seen_low_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      lat_addr_q  <= lat_addr_d;
      lat_we_q    <= lat_we_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      preq_q      <= preq_d;
      rdreq_q     <= rdreq_d;
      wrreq_q     <= wrreq_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      seen_low_q  <= seen_low_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign cpu_rdata      = rdata_q;
  assign cpu_ready      = ready_q;
  assign processor_req  = preq_q;
  assign mem_read_req   = rdreq_q;
  assign mem_write_req  = wrreq_q;
  assign addr           = addr_q;
  assign mem_write_data = wdata_q;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: directed scenarios then random traffic, checked against an
// architectural memory/cache-residency model and a randomized-latency memory responder.
module tb_l1_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        processor_req, mem_read_req, mem_write_req;
  logic [13:0] addr;
  logic [15:0] mem_write_data, mem_read_data;
  logic        processor_resp;
  logic [15:0] hit_count, miss_count;

  l1_cache_ctrl #(.DATA_SIZE(2), .NUM_LINES(8), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .processor_req(processor_req), .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .addr(addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .processor_resp(processor_resp), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory (what the port holds) and architectural memory (what the core must see)
  logic [15:0] mem_b [0:16383];
  logic [15:0] arch  [0:16383];

  bit          m_valid [0:7];
  bit          m_dirty [0:7];
  logic [13:0] m_addr  [0:7];
  int          m_hits, m_misses;

  typedef struct {
    logic        wr;
    logic [13:0] a;
    logic [15:0] d;
    int          t;
  } txn_t;
  txn_t txq[$];

  bit force_cfg = 1'b0;
  int f_s, f_l;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_dirty[i]) arch[m_addr[i]] = mem_b[m_addr[i]];
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_addr[i]  = '0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Memory responder: optional stale-high cycles, then low cycles, then a completing high
  initial begin : responder
    bit          busy = 1'b0;
    bit          had_rst, stable;
    int          dur, s, l;
    logic        r_wr;
    logic [13:0] r_addr;
    logic [15:0] r_data;
    processor_resp = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (processor_req && !busy) begin
        busy    = 1'b1;
        dur     = 0;
        had_rst = 1'b0;
        stable  = 1'b1;
        r_wr    = mem_write_req;
        r_addr  = addr;
        r_data  = mem_write_data;
        check_eq("rw_excl", 32'(mem_read_req ^ mem_write_req), 32'd1);
        if (force_cfg) begin
          s = f_s;
          l = f_l;
        end else begin
          s = $urandom_range(0, 2);
          l = $urandom_range(1, 3);
        end
      end
      if (busy) begin
        if (reset) had_rst = 1'b1;
        if (processor_req) begin
          if (mem_write_req !== r_wr || mem_read_req !== !r_wr || addr !== r_addr ||
              (r_wr && mem_write_data !== r_data)) stable = 1'b0;
          if (dur < s) begin
            processor_resp = 1'b1;
            mem_read_data  = 16'($urandom);
          end else if (dur < s + l) begin
            processor_resp = 1'b0;
            mem_read_data  = 16'($urandom);
          end else begin
            processor_resp = 1'b1;
            mem_read_data  = mem_b[r_addr];
          end
          dur++;
        end else begin
          busy = 1'b0;
          if (!had_rst) begin
            check_eq("txn_len", 32'(dur), 32'(s + l + 1));
            check_eq("txn_stable", 32'(stable), 32'd1);
            if (r_wr) mem_b[r_addr] = r_data;
            txq.push_back('{wr: r_wr, a: r_addr, d: r_data, t: s + l + 1});
          end
          processor_resp = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [13:0] a, input logic [15:0] wd,
                        output logic [15:0] rd);
    int          idx, exp_n, cycles, lat, npop;
    bit          got;
    txn_t        exp_t [2];
    txn_t        tr;
    logic [15:0] exp_rd;
    idx   = int'(a[2:0]);
    exp_n = 0;
    if (m_valid[idx] && m_addr[idx] == a) begin
      if (m_hits < 65535) m_hits++;
      if (we) begin
        arch[a]      = wd;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      if (m_misses < 65535) m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_t[exp_n] = '{wr: 1'b1, a: m_addr[idx], d: arch[m_addr[idx]], t: 0};
        exp_n++;
      end
      if (!we) begin
        exp_t[exp_n] = '{wr: 1'b0, a: a, d: 16'h0, t: 0};
        exp_n++;
      end
      m_valid[idx] = 1'b1;
      m_addr[idx]  = a;
      m_dirty[idx] = we;
      if (we) arch[a] = wd;
    end
    exp_rd = arch[a];

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    cycles    = 0;
    got       = 1'b0;
    while (!got && cycles < 300) begin
      @(negedge clk);
      #1;
      cycles++;
      if (cpu_ready) got = 1'b1;
    end
    cpu_req = 1'b0;
    check_eq("ready_seen", 32'(got), 32'd1);
    rd = cpu_rdata;
    if (!we) check_eq("rdata", 32'(cpu_rdata), 32'(exp_rd));
    check_eq("txn_cnt", 32'(txq.size()), 32'(exp_n));
    lat  = 1;
    npop = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (txq.size() > 0) begin
        tr = txq.pop_front();
        npop++;
        lat += tr.t;
        check_eq("txn_wr", 32'(tr.wr), 32'(exp_t[i].wr));
        check_eq("txn_addr", 32'(tr.a), 32'(exp_t[i].a));
        if (exp_t[i].wr) check_eq("txn_wdata", 32'(tr.d), 32'(exp_t[i].d));
      end
    end
    if (npop == 2) lat += 1;
    txq.delete();
    check_eq("latency", 32'(cycles), 32'(lat));
    check_eq("hit_cnt", 32'(hit_count), 32'(m_hits));
    check_eq("miss_cnt", 32'(miss_count), 32'(m_misses));
    check_eq("port_idle", 32'({processor_req, mem_read_req, mem_write_req}), 32'd0);
    check_eq("addr_idle", 32'(addr), 32'd0);
    @(negedge clk);
    #1;
    check_eq("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(cpu_ready), 32'd0);
    check_eq({tag, "_reqs"}, 32'({processor_req, mem_read_req, mem_write_req}), 32'd0);
    check_eq({tag, "_addr"}, 32'(addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_write_data), 32'd0);
    check_eq({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
    check_eq({tag, "_cnts"}, {hit_count, miss_count}, 32'd0);
  endtask

  initial begin : main
    logic [15:0] rd;
    logic [13:0] a;
    int          waited;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < 16384; i++) begin
      mem_b[i] = 16'(i + 1);
      arch[i]  = 16'(i + 1);
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    #1;

    cpu_op(1'b0, 14'h0005, 16'h0, rd);
    check_eq("cold_rdata", 32'(rd), 32'h0006);
    check_eq("cold_miss", 32'(miss_count), 32'd1);
    cpu_op(1'b0, 14'h0005, 16'h0, rd);
    check_eq("rehit_cnt", 32'(hit_count), 32'd1);
    cpu_op(1'b1, 14'h0005, 16'hBEEF, rd);
    cpu_op(1'b0, 14'h0005, 16'h0, rd);
    check_eq("whit_rdata", 32'(rd), 32'hBEEF);
    cpu_op(1'b0, 14'h000D, 16'h0, rd);
    check_eq("evict_rdata", 32'(rd), 32'h000E);
    check_eq("evict_mem", 32'(mem_b[5]), 32'hBEEF);
    cpu_op(1'b1, 14'h0003, 16'h1234, rd);

    force_cfg = 1'b1;
    f_s = 1; f_l = 1;
    cpu_op(1'b0, 14'h0025, 16'h0, rd);
    f_s = 2; f_l = 2;
    cpu_op(1'b0, 14'h0035, 16'h0, rd);

    // Reset while a fill is outstanding
    f_s = 0; f_l = 6;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 14'h0016;
    waited   = 0;
    while (!processor_req && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check_eq("fill_started", 32'(processor_req), 32'd1);
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("midrst");
    reset = 1'b0;
    model_reset();
    txq.delete();
    force_cfg = 1'b0;
    @(negedge clk);
    #1;
    cpu_op(1'b0, 14'h0016, 16'h0, rd);
    check_eq("post_rst_miss", 32'(miss_count), 32'd1);
    cpu_op(1'b0, 14'h0003, 16'h0, rd);
    check_eq("dirty_discard", 32'(rd), 32'h0004);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = 14'h3FF8 | 14'($urandom_range(0, 7));
      else a = 14'($urandom_range(0, 31));
      cpu_op(1'($urandom_range(0, 1)), a, 16'($urandom), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
